// File: rtl/jtsdram_score.sv
// Result scoreboard for the SDRAM self-test: counts passes and error events,
// records the pass of the first failure, watches for a stalled test and drives the LED.
`timescale 1ns/1ps
module jtsdram_score #(
    parameter int BLINK_FRAMES   = 30,
    parameter int TIMEOUT_FRAMES = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        LVBL,
    input  logic        dwnld_busy,
    input  logic        bad,
    output logic [15:0] pass_cnt,
    output logic [15:0] err_cnt,
    output logic        fail,
    output logic [15:0] first_fail,
    output logic        stall,
    output logic        led,
    output logic        running
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROG  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_C   = 16'(TIMEOUT_FRAMES);
    localparam logic [15:0] BLINK_TOP_C = 16'(BLINK_FRAMES - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_q, state_d;
    logic        lvbl_q, lvbl_d, busy_q, busy_d, bad_q, bad_d;
    logic [15:0] pass_q, pass_d, err_q, err_d, ff_q, ff_d;
    logic [15:0] frame_q, frame_d, blink_cnt_q, blink_cnt_d;
    logic        fail_q, fail_d, stall_q, stall_d, blink_q, blink_d;
    logic        busy_rise_s, busy_fall_s, busy_edge_s, bad_rise_s, lvbl_fall_s, running_s;

    assign busy_rise_s = dwnld_busy & ~busy_q;
    assign busy_fall_s = ~dwnld_busy & busy_q;
    assign busy_edge_s = busy_rise_s | busy_fall_s;
    assign bad_rise_s  = bad & ~bad_q;
    assign lvbl_fall_s = ~LVBL & lvbl_q;
    assign running_s   = (state_q != IDLE);

    // Next-state computation for the FSM, counters, flags and edge registers
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        err_d       = err_q;
        ff_d        = ff_q;
        fail_d      = fail_q;
        stall_d     = stall_q;
        frame_d     = frame_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        lvbl_d      = LVBL;
        busy_d      = dwnld_busy;
        bad_d       = bad;

        case (state_q)
            IDLE: begin
                if (busy_rise_s) state_d = PROG;
                else             state_d = IDLE;
            end
            PROG: begin
                if (busy_fall_s) state_d = CHECK;
                else             state_d = PROG;
            end
            CHECK: begin
                if (busy_rise_s) begin
                    state_d = PROG;
                    pass_d  = sat_inc(pass_q);
                end else begin
                    state_d = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase

        // first_fail captures the pre-increment pass count, even on a pass boundary
        if (bad_rise_s) begin
            err_d = sat_inc(err_q);
            if (!fail_q) begin
                fail_d = 1'b1;
                ff_d   = pass_q;
            end else begin
                fail_d = fail_q;
            end
        end else begin
            err_d = err_q;
        end

        if (busy_edge_s)                             frame_d = 16'd0;
        else if (lvbl_fall_s && frame_q < TIMEOUT_C) frame_d = frame_q + 16'd1;
        else                                         frame_d = frame_q;

        if (running_s && !busy_edge_s && frame_d == TIMEOUT_C) stall_d = 1'b1;
        else                                                   stall_d = stall_q;

        if (!running_s) begin
            blink_cnt_d = 16'd0;
        end else if (lvbl_fall_s) begin
            if (blink_cnt_q >= BLINK_TOP_C) begin
                blink_cnt_d = 16'd0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end

        // Clear beats any simultaneous event; FSM and edge registers keep going
        if (clr) begin
            pass_d      = 16'd0;
            err_d       = 16'd0;
            ff_d        = 16'd0;
            fail_d      = 1'b0;
            stall_d     = 1'b0;
            frame_d     = 16'd0;
            blink_cnt_d = 16'd0;
            blink_d     = 1'b0;
        end else begin
            blink_d = blink_d;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lvbl_q      <= 1'b0;
            busy_q      <= 1'b0;
            bad_q       <= 1'b0;
            pass_q      <= 16'd0;
            err_q       <= 16'd0;
            ff_q        <= 16'd0;
            fail_q      <= 1'b0;
            stall_q     <= 1'b0;
            frame_q     <= 16'd0;
            blink_cnt_q <= 16'd0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lvbl_q      <= lvbl_d;
            busy_q      <= busy_d;
            bad_q       <= bad_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            ff_q        <= ff_d;
            fail_q      <= fail_d;
            stall_q     <= stall_d;
            frame_q     <= frame_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign pass_cnt   = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;
    assign fail       = fail_q;
    assign stall      = stall_q;
    assign running    = running_s;
    assign led        = (fail_q || stall_q) ? 1'b1 : (running_s ? blink_q : 1'b0);
endmodule

// File: tb/tb_jtsdram_score.sv
// Directed bench for jtsdram_score with short blink/timeout periods.
`timescale 1ns/1ps
module tb_jtsdram_score;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        LVBL = 1'b1;
    logic        dwnld_busy = 1'b0;
    logic        bad = 1'b0;
    logic [15:0] pass_cnt, err_cnt, first_fail;
    logic        fail, stall, led, running;
    int          checks = 0;
    int          failures = 0;

    jtsdram_score #(.BLINK_FRAMES(3), .TIMEOUT_FRAMES(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .LVBL(LVBL),
        .dwnld_busy(dwnld_busy), .bad(bad),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt), .fail(fail),
        .first_fail(first_fail), .stall(stall), .led(led), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        LVBL = 1'b0; cyc(1);
        LVBL = 1'b1; cyc(1);
    endtask

    task automatic pulse(input int hi, input int lo);
        dwnld_busy = 1'b1; cyc(hi);
        dwnld_busy = 1'b0; cyc(lo);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pass"},  pass_cnt, 16'd0);
        check({tag, "_err"},   err_cnt, 16'd0);
        check({tag, "_ff"},    first_fail, 16'd0);
        check({tag, "_fail"},  {15'd0, fail}, 16'd0);
        check({tag, "_stall"}, {15'd0, stall}, 16'd0);
        check({tag, "_led"},   {15'd0, led}, 16'd0);
    endtask

    initial begin
        cyc(3);
        check_all_zero("in_reset");
        check("in_reset_run", {15'd0, running}, 16'd0);
        rst_n = 1'b1;
        cyc(100);
        check_all_zero("idle");
        check("idle_run", {15'd0, running}, 16'd0);

        // Three pulses: one entry plus two pass boundaries, then an error
        pulse(20, 200); pulse(20, 200); pulse(20, 200);
        check("pass2", pass_cnt, 16'd2);
        check("run_check", {15'd0, running}, 16'd1);
        bad = 1'b1; cyc(1);
        check("err1_fail", {15'd0, fail}, 16'd1);
        check("err1_ff", first_fail, 16'd2);
        check("err1_cnt", err_cnt, 16'd1);
        check("err1_led", {15'd0, led}, 16'd1);
        bad = 1'b0; cyc(1);
        pulse(20, 200);
        check("pass3", pass_cnt, 16'd3);
        bad = 1'b1; cyc(1);
        check("err2_cnt", err_cnt, 16'd2);
        check("err2_ff", first_fail, 16'd2);
        bad = 1'b0; cyc(1);

        clr = 1'b1; cyc(1); clr = 1'b0;
        check_all_zero("clr1");
        check("clr1_run", {15'd0, running}, 16'd1);

        // Blink toggles on every third frame
        frame(); frame();
        check("blink_off", {15'd0, led}, 16'd0);
        frame();
        check("blink_on", {15'd0, led}, 16'd1);

        // Enter PROG and let the watchdog expire
        dwnld_busy = 1'b1; cyc(1);
        check("pass_after_clr", pass_cnt, 16'd1);
        frame(); frame(); frame();
        check("blink_back_off", {15'd0, led}, 16'd0);
        check("no_stall_3", {15'd0, stall}, 16'd0);
        LVBL = 1'b0; cyc(1);
        check("stall_set", {15'd0, stall}, 16'd1);
        check("stall_led", {15'd0, led}, 16'd1);
        LVBL = 1'b1; cyc(1);
        clr = 1'b1; cyc(1); clr = 1'b0;
        check("stall_clr", {15'd0, stall}, 16'd0);

        // Busy edge coinciding with the fourth frame keeps stall clear
        frame(); frame(); frame();
        LVBL = 1'b0; dwnld_busy = 1'b0; cyc(1);
        check("stall_race", {15'd0, stall}, 16'd0);
        check("race_run", {15'd0, running}, 16'd1);
        LVBL = 1'b1; cyc(1);
        frame();
        check("stall_race2", {15'd0, stall}, 16'd0);

        // Bad rise on the pass boundary
        for (int i = 0; i < 5; i++) pulse(2, 3);
        check("pass5", pass_cnt, 16'd5);
        dwnld_busy = 1'b1; bad = 1'b1; cyc(1);
        check("sim_ff", first_fail, 16'd5);
        check("sim_pass", pass_cnt, 16'd6);
        check("sim_err", err_cnt, 16'd1);
        dwnld_busy = 1'b0; bad = 1'b0; cyc(2);
        clr = 1'b1; bad = 1'b1; cyc(1);
        clr = 1'b0;
        check_all_zero("clr_bad");
        check("clr_bad_run", {15'd0, running}, 16'd1);
        cyc(1);
        check("clr_lost_event", err_cnt, 16'd0);
        bad = 1'b0; cyc(1);

        // Saturation
        force dut.err_q = 16'hFFFF;
        cyc(1);
        release dut.err_q;
        cyc(1);
        check("sat_preload", err_cnt, 16'hFFFF);
        bad = 1'b1; cyc(1);
        check("sat_hold", err_cnt, 16'hFFFF);
        check("sat_fail", {15'd0, fail}, 16'd1);
        bad = 1'b0; cyc(1);

        // Asynchronous reset mid-pass
        dwnld_busy = 1'b1; cyc(1);
        check("pre_rst_pass", pass_cnt, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        check("async_rst_run", {15'd0, running}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        check("rst_busy_rise_run", {15'd0, running}, 16'd1);
        check("rst_busy_rise_pass", pass_cnt, 16'd0);
        dwnld_busy = 1'b0; cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
